ex_stage_pipe: RTL and testbench
================================

# ex_stage_pipe

Parametrised, registered execute stage for the pipelined CPU, replacing the purely combinational execute logic. It resolves operand forwarding, evaluates single-cycle ALU operations or an iterative multiply, and holds the result in an EX/MEM output register behind a valid/ready handshake. The N/V/Z flags are held in a flag register with per-flag update rules. It sits between the ID/EX register and the memory stage.

## Interface
- DATA_W, 16, datapath width; must be even and ≥8; H = DATA_W/2.
- REG_W, 4, destination register index width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid / in_ready  in / out  1 / 1  upstream handshake; an instruction is accepted when both are high.
- rs_val, rt_val, imm, pc_plus2  in  DATA_W each  ID/EX operands.
- use_imm, lhb, llb, mul  in  1 each  control bits; `mul` selects the multiply path.
- alu_op  in  4  opcode encoded per `ex_pkg`.
- fwd_a, fwd_b  in  2 each  forwarding selects.
- fwd_exmem, fwd_memwb  in  DATA_W each  forwarded values.
- dest_in  in  REG_W  destination register index.
- wr_in  in  1  register-write enable.
- flush  in  1  synchronous kill.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- out_result, out_store  out  DATA_W each  ALU result and forwarded operand B (store data).
- out_dest  out  REG_W  registered destination index.
- out_wr  out  1  registered write enable.
- flag_n, flag_v, flag_z  out  1 each  flag register outputs.

## Operation
- **Operand A select (`fwd_a`):**
  - 00: rs_val.
  - 10: fwd_exmem.
  - 11: {fwd_exmem[H-1:0], fwd_memwb[H-1:0]}.
  - 01, depends on control bits:
    - lhb=1: {fwd_memwb[H-1:0], rs_val[H-1:0]}.
    - else llb=1: {H'0, fwd_memwb[H-1:0]}.
    - else: fwd_memwb.
- **Operand B select:** alu_op==PCS gives pc_plus2; else use_imm=1 gives imm; else the same forwarding mux as A, driven by `fwd_b` and rt_val.
- **Store data:** out_store always receives the forwarded rt value, never imm or pc_plus2.
- **ALU operations:**
  - ADD, SUB: signed saturating to DATA_W.
  - XOR.
  - SLL, SRA, ROR: shift amount is B[$clog2(DATA_W)-1:0].
  - PADDSB: DATA_W/4 independent 4-bit signed-saturating lanes.
  - RED: sign-extended sum of all bytes of A and B.
  - LW, SW: (A & ~1) + B, wrapping.
  - LLB: {A[DATA_W-1:H], B[H-1:0]}.
  - LHB: {B[H-1:0], A[H-1:0]}.
  - PCS, B, BR, HLT: result = B.
- **Flags:**
  - Z is written by ADD, SUB, XOR, SLL, SRA, ROR.
  - N and V are written by ADD and SUB only; V is set when saturation occurred.
  - Other ops and MUL leave the flags unchanged.
- **Multiply:**
  - `mul` takes priority over alu_op.
  - Unsigned shift-add, one bit per cycle; result is the low DATA_W bits of the product.
- **Control FSM:**
  - IDLE: on accept with mul=1 go to MUL; otherwise stay in IDLE.
  - MUL: runs DATA_W iterations, counting down, then goes to DONE.
  - DONE: when the output register is free, load it and return to IDLE.
- **in_ready** = (state==IDLE) && (!out_valid || out_ready) && !flush.

## Timing
- **Reset:** out_valid=0, out_result=0, out_store=0, out_dest=0, out_wr=0, all flags 0, FSM in IDLE. in_ready is 1 immediately after reset deassertion.
- **Single-cycle ops:** accepted at edge k; out_* and flags update at edge k.
- **MUL:**
  - Operands are captured at the accept edge k.
  - Counter iterations complete at edges k+1..k+DATA_W.
  - Result loads into the output register at the next edge with the output register free, earliest k+DATA_W+1.
  - in_ready=0 throughout.
- **Backpressure:** out_valid && !out_ready holds all out_* stable and blocks acceptance.
- **Simultaneous events:**
  - Output drain and new accept in the same cycle is legal (full throughput of 1/cycle for single-cycle ops).
  - flush beats in_valid.
- **Flush:**
  - Clears out_valid at the next edge.
  - Aborts MUL/DONE to IDLE.
  - Discards the pending result and its flag update.
- **Reset mid-MUL:** immediate return to IDLE; no output is produced.

## Structure
- **`ex_pkg`:**
  - 4-bit opcode constants: ADD=0, SUB=1, XOR=2, RED=3, SLL=4, SRA=5, ROR=6, PADDSB=7, LW=8, SW=9, LLB=A, LHB=B, B=C, BR=D, PCS=E, HLT=F.
  - Forwarding-select constants.
  - FSM state enum {IDLE, MUL, DONE}.
- **`ex_mul_iter`** (sub-module):
  - Ports: clk, rst, start, abort, a, b → busy, done, product.
  - Internal counter and accumulator.
- **Top level:** forwarding muxes, ALU, output/flag registers, FSM.

## Test plan
- **ADD saturation:** A=0x7FFF, B=0x0001, ADD → out_result=0x7FFF, V=1, N=0, Z=0 one edge after accept.
- **Concatenated forwarding:** fwd_a=11, fwd_exmem=0x12AB, fwd_memwb=0x34CD, XOR with imm=0xABCD (use_imm=1) → out_result=0x0000, Z=1.
- **LHB forwarding merge:** fwd_a=01, lhb=1, rs_val=0x1234, fwd_memwb=0x0056, op=PCS not used, op=XOR, B=0 → out_result=0x5634.
- **MUL:** MUL 0x0003×0xFFFF → out_result=0xFFFD, out_valid 17 edges after accept; in_ready=0 during iterations; flags unchanged from prior values.
- **Backpressure:** out_ready=0 for 3 cycles → out_* stable, in_ready=0; a queued ADD is accepted in the cycle out_ready returns to 1.
- **Abort mid-MUL:** flush 5 cycles after a MUL accept → no out_valid, in_ready=1 next cycle; repeat with rst asserted → same result.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: opcodes, forwarding selects, FSM states.
package ex_pkg;

  // ALU opcodes carried on alu_op
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // Forwarding selects for operand A / operand B
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_CAT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } ex_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// done is high during the cycle whose closing edge completes the last iteration.
module ex_mul_iter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] acc_reg;
  logic              busy_reg;

  assign busy    = busy_reg;
  assign done    = busy_reg && (cnt_reg == CNT_W'(1));
  assign product = acc_reg;

  // Capture operands on start, then shift-add once per cycle, counting down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (abort) begin
      busy_reg <= 1'b0;
    end else if (start) begin
      a_reg    <= a;
      b_reg    <= b;
      acc_reg  <= '0;
      cnt_reg  <= CNT_W'(DATA_W);
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      if (b_reg[0]) begin
        acc_reg <= acc_reg + a_reg;
      end
      a_reg   <= {a_reg[DATA_W-2:0], 1'b0};
      b_reg   <= {1'b0, b_reg[DATA_W-1:1]};
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// Registered execute stage: operand forwarding, single-cycle ALU, iterative
// multiply, EX/MEM output register with valid/ready, and N/V/Z flag register.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc_plus2,
  input  logic              use_imm,
  input  logic              lhb,
  input  logic              llb,
  input  logic              mul,
  input  logic [3:0]        alu_op,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] fwd_exmem,
  input  logic [DATA_W-1:0] fwd_memwb,
  input  logic [REG_W-1:0]  dest_in,
  input  logic              wr_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store,
  output logic [REG_W-1:0]  out_dest,
  output logic              out_wr,
  output logic              flag_n,
  output logic              flag_v,
  output logic              flag_z
);
  localparam int H      = DATA_W / 2;
  localparam int SH_W   = $clog2(DATA_W);
  localparam int LANES  = DATA_W / 4;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  ex_state_e         state_reg;
  logic              accept;
  logic              out_free;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] fwd_b_val;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] paddsb_res;
  logic [DATA_W-1:0] red_acc;
  logic [DATA_W:0]   sum_ext;
  logic [SH_W-1:0]   shamt;
  logic              alu_wr_z;
  logic              alu_wr_nv;
  logic              alu_v;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] mul_store_reg;
  logic [REG_W-1:0]  mul_dest_reg;
  logic              mul_wr_reg;

  // Select 01 merges the MEM/WB value with the register value for LHB/LLB
  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] base,
    input logic [DATA_W-1:0] exmem,
    input logic [DATA_W-1:0] memwb,
    input logic              lhb_c,
    input logic              llb_c
  );
    case (sel)
      FWD_REG:   return base;
      FWD_EXMEM: return exmem;
      FWD_CAT:   return {exmem[H-1:0], memwb[H-1:0]};
      FWD_MEMWB: begin
        if (lhb_c)      return {memwb[H-1:0], base[H-1:0]};
        else if (llb_c) return {{(DATA_W-H){1'b0}}, memwb[H-1:0]};
        else            return memwb;
      end
      default:   return base;
    endcase
  endfunction

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state_reg == IDLE) && !mul_busy && out_free && !flush;
  assign accept   = in_valid && in_ready;

  // Operand A/B forwarding; store data is always the forwarded rt value
  always_comb begin
    opa       = fwd_mux(fwd_a, rs_val, fwd_exmem, fwd_memwb, lhb, llb);
    fwd_b_val = fwd_mux(fwd_b, rt_val, fwd_exmem, fwd_memwb, lhb, llb);
    if (alu_op == OP_PCS)  opb = pc_plus2;
    else if (use_imm)      opb = imm;
    else                   opb = fwd_b_val;
  end

  // Four-bit signed saturating lanes for PADDSB
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [4:0] lane_sum;
    assign lane_sum = {opa[4*gi+3], opa[4*gi +: 4]} + {opb[4*gi+3], opb[4*gi +: 4]};
    assign paddsb_res[4*gi +: 4] = (lane_sum[4] != lane_sum[3]) ?
                                   (lane_sum[4] ? 4'h8 : 4'h7) : lane_sum[3:0];
  end
  if (LANES * 4 < DATA_W) begin : g_lane_pad
    assign paddsb_res[DATA_W-1:LANES*4] = '0;
  end

  // Single-cycle ALU and which flags it is allowed to write
  always_comb begin
    shamt     = opb[SH_W-1:0];
    sum_ext   = (alu_op == OP_SUB) ? ({opa[DATA_W-1], opa} - {opb[DATA_W-1], opb})
                                   : ({opa[DATA_W-1], opa} + {opb[DATA_W-1], opb});
    red_acc   = '0;
    alu_res   = opb;
    alu_wr_z  = 1'b0;
    alu_wr_nv = 1'b0;
    alu_v     = 1'b0;
    case (alu_op)
      OP_ADD, OP_SUB: begin
        alu_v     = sum_ext[DATA_W] != sum_ext[DATA_W-1];
        alu_res   = alu_v ? (sum_ext[DATA_W] ? SAT_MIN : SAT_MAX) : sum_ext[DATA_W-1:0];
        alu_wr_z  = 1'b1;
        alu_wr_nv = 1'b1;
      end
      OP_XOR: begin
        alu_res  = opa ^ opb;
        alu_wr_z = 1'b1;
      end
      OP_SLL: begin
        alu_res  = opa << shamt;
        alu_wr_z = 1'b1;
      end
      OP_SRA: begin
        alu_res  = $signed(opa) >>> shamt;
        alu_wr_z = 1'b1;
      end
      OP_ROR: begin
        alu_res  = (opa >> shamt) | (opa << (DATA_W - int'(shamt)));
        alu_wr_z = 1'b1;
      end
      OP_PADDSB: alu_res = paddsb_res;
      OP_RED: begin
        for (int i = 0; i < NBYTES; i++) begin
          red_acc = red_acc + DATA_W'($signed(opa[8*i +: 8])) + DATA_W'($signed(opb[8*i +: 8]));
        end
        alu_res = red_acc;
      end
      OP_LW, OP_SW: alu_res = {opa[DATA_W-1:1], 1'b0} + opb;
      OP_LLB:       alu_res = {opa[DATA_W-1:H], opb[H-1:0]};
      OP_LHB:       alu_res = {opb[H-1:0], opa[H-1:0]};
      OP_PCS, OP_B, OP_BR, OP_HLT: alu_res = opb;
      default:      alu_res = opb;
    endcase
  end

  ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && mul),
    .abort   (flush),
    .a       (opa),
    .b       (opb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM and EX/MEM output register; flush discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_store     <= '0;
      out_dest      <= '0;
      out_wr        <= 1'b0;
      mul_store_reg <= '0;
      mul_dest_reg  <= '0;
      mul_wr_reg    <= 1'b0;
    end else if (flush) begin
      state_reg <= IDLE;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (accept && mul) begin
            mul_store_reg <= fwd_b_val;
            mul_dest_reg  <= dest_in;
            mul_wr_reg    <= wr_in;
            state_reg     <= MUL;
          end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= alu_res;
            out_store  <= fwd_b_val;
            out_dest   <= dest_in;
            out_wr     <= wr_in;
          end
        end
        MUL: begin
          if (mul_done) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_free) begin
            out_valid  <= 1'b1;
            out_result <= mul_product;
            out_store  <= mul_store_reg;
            out_dest   <= mul_dest_reg;
            out_wr     <= mul_wr_reg;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Flag register: written only by accepted single-cycle ops that own the flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      flag_z <= 1'b0;
    end else if (accept && !mul) begin
      if (alu_wr_z) begin
        flag_z <= (alu_res == '0);
      end
      if (alu_wr_nv) begin
        flag_n <= alu_res[DATA_W-1];
        flag_v <= alu_v;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe (DATA_W=16) with a behavioural model.
module tb_ex_stage_pipe;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, use_imm, lhb, llb, mul, wr_in, flush, out_ready;
  logic [15:0] rs_val, rt_val, imm, pc_plus2, fwd_exmem, fwd_memwb;
  logic [3:0]  alu_op, dest_in;
  logic [1:0]  fwd_a, fwd_b;
  logic        in_ready, out_valid, out_wr, flag_n, flag_v, flag_z;
  logic [15:0] out_result, out_store;
  logic [3:0]  out_dest;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the output register and flags
  logic        m_valid, m_wr, m_n, m_v, m_z;
  logic [15:0] m_result, m_store;
  logic [3:0]  m_dest;

  always #5 clk = ~clk;

  ex_stage_pipe #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .pc_plus2(pc_plus2),
    .use_imm(use_imm), .lhb(lhb), .llb(llb), .mul(mul), .alu_op(alu_op),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
    .dest_in(dest_in), .wr_in(wr_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store(out_store), .out_dest(out_dest), .out_wr(out_wr),
    .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int s16(input logic [15:0] v);
    int x;
    x = int'(v);
    if (x >= 32768) x -= 65536;
    return x;
  endfunction

  function automatic logic [15:0] ref_fwd(input logic [1:0] sel, input logic [15:0] base,
                                          input logic [15:0] exm, input logic [15:0] mwb,
                                          input logic l_hb, input logic l_lb);
    logic [15:0] r;
    if (sel == 2'b00)      r = base;
    else if (sel == 2'b10) r = exm;
    else if (sel == 2'b11) r = (exm << 8) | (mwb & 16'h00FF);
    else if (l_hb)         r = (mwb << 8) | (base & 16'h00FF);
    else if (l_lb)         r = mwb & 16'h00FF;
    else                   r = mwb;
    return r;
  endfunction

  // Arithmetic reference for every single-cycle opcode
  task automatic ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic wz, output logic wnv,
                         output logic v);
    int ai, bi, sa, sb, s, sh, t, x, y;
    ai = int'(a); bi = int'(b); sa = s16(a); sb = s16(b); sh = bi % 16;
    wz = 1'b0; wnv = 1'b0; v = 1'b0; res = b;
    case (op)
      OP_ADD, OP_SUB: begin
        s = (op == OP_ADD) ? sa + sb : sa - sb;
        v = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        res = 16'(s); wz = 1'b1; wnv = 1'b1;
      end
      OP_XOR: begin res = a ^ b; wz = 1'b1; end
      OP_SLL: begin res = 16'(ai << sh); wz = 1'b1; end
      OP_SRA: begin res = 16'(sa >>> sh); wz = 1'b1; end
      OP_ROR: begin res = 16'((ai >> sh) | (ai << (16 - sh))); wz = 1'b1; end
      OP_PADDSB: begin
        t = 0;
        for (int l = 0; l < 4; l++) begin
          x = (ai >> (4 * l)) & 15; if (x >= 8) x -= 16;
          y = (bi >> (4 * l)) & 15; if (y >= 8) y -= 16;
          s = x + y;
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          t = t | ((s & 15) << (4 * l));
        end
        res = 16'(t);
      end
      OP_RED: begin
        t = 0;
        for (int k = 0; k < 2; k++) begin
          x = (ai >> (8 * k)) & 255; if (x >= 128) x -= 256;
          y = (bi >> (8 * k)) & 255; if (y >= 128) y -= 256;
          t = t + x + y;
        end
        res = 16'(t);
      end
      OP_LW, OP_SW: res = 16'((ai & 32'hFFFE) + bi);
      OP_LLB:       res = 16'((ai & 32'hFF00) | (bi & 32'h00FF));
      OP_LHB:       res = 16'(((bi & 32'h00FF) << 8) | (ai & 32'h00FF));
      default:      res = b;
    endcase
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_result = '0; m_store = '0; m_dest = '0; m_wr = 1'b0;
    m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; use_imm = 1'b0; lhb = 1'b0; llb = 1'b0; mul = 1'b0; wr_in = 1'b0;
    flush = 1'b0; out_ready = 1'b1; rs_val = '0; rt_val = '0; imm = '0; pc_plus2 = '0;
    fwd_exmem = '0; fwd_memwb = '0; alu_op = OP_ADD; dest_in = '0; fwd_a = 2'b00; fwd_b = 2'b00;
  endtask

  // Advance one clock for single-cycle traffic and update the model
  task automatic apply_edge();
    logic        acc, wz, wnv, v;
    logic [15:0] a, b, st, res;
    acc = in_valid && !flush && (!m_valid || out_ready) && !mul;
    a   = ref_fwd(fwd_a, rs_val, fwd_exmem, fwd_memwb, lhb, llb);
    st  = ref_fwd(fwd_b, rt_val, fwd_exmem, fwd_memwb, lhb, llb);
    b   = (alu_op == OP_PCS) ? pc_plus2 : (use_imm ? imm : st);
    ref_alu(alu_op, a, b, res, wz, wnv, v);
    @(posedge clk); #1;
    if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1; m_result = res; m_store = st; m_dest = dest_in; m_wr = wr_in;
      if (wz) m_z = (res == 16'h0000);
      if (wnv) begin m_n = res[15]; m_v = v; end
      $display("txn op=%h a=%h b=%h result=%h store=%h", alu_op, a, b, res, st);
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_result, out_store, out_dest, out_wr, flag_n, flag_v, flag_z} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0",
               {out_valid, out_result, out_store, out_dest, out_wr, flag_n, flag_v, flag_z});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    model_reset();
  endtask

  task automatic test_add_sat();
    set_idle();
    in_valid = 1'b1; alu_op = OP_ADD; rs_val = 16'h7FFF; use_imm = 1'b1; imm = 16'h0001;
    rt_val = 16'h5555; dest_in = 4'h3; wr_in = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_sat_ready: got %b required 1", in_ready); end
    apply_edge();
    n_checks++;
    if ({out_valid, out_result, out_store, out_dest, out_wr} !== {1'b1, 16'h7FFF, 16'h5555, 4'h3, 1'b1}) begin
      n_fail++;
      $display("FAIL add_sat_out: got %b %h %h %h %b required 1 7fff 5555 3 1",
               out_valid, out_result, out_store, out_dest, out_wr);
    end
    n_checks++;
    if ({flag_n, flag_v, flag_z} !== 3'b010) begin
      n_fail++; $display("FAIL add_sat_flags: got nvz=%b required 010", {flag_n, flag_v, flag_z});
    end
    in_valid = 1'b0;
    apply_edge();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_sat_drain: got %b required 0", out_valid); end
  endtask

  task automatic test_fwd_cat();
    set_idle();
    in_valid = 1'b1; alu_op = OP_XOR; fwd_a = 2'b11; fwd_exmem = 16'h12AB; fwd_memwb = 16'h34CD;
    use_imm = 1'b1; imm = 16'hABCD;
    apply_edge();
    n_checks++;
    if ({out_valid, out_result, flag_n, flag_v, flag_z} !== {1'b1, 16'h0000, 3'b011}) begin
      n_fail++;
      $display("FAIL fwd_cat: got v=%b res=%h nvz=%b required v=1 res=0000 nvz=011",
               out_valid, out_result, {flag_n, flag_v, flag_z});
    end
    in_valid = 1'b0;
    apply_edge();
  endtask

  task automatic test_lhb_merge();
    set_idle();
    in_valid = 1'b1; alu_op = OP_XOR; fwd_a = 2'b01; lhb = 1'b1; rs_val = 16'h1234;
    fwd_memwb = 16'h0056; use_imm = 1'b1; imm = 16'h0000;
    apply_edge();
    n_checks++;
    if ({out_valid, out_result, flag_n, flag_v, flag_z} !== {1'b1, 16'h5634, 3'b010}) begin
      n_fail++;
      $display("FAIL lhb_merge: got v=%b res=%h nvz=%b required v=1 res=5634 nvz=010",
               out_valid, out_result, {flag_n, flag_v, flag_z});
    end
    in_valid = 1'b0;
    apply_edge();
  endtask

  task automatic test_mul();
    int bad;
    set_idle();
    in_valid = 1'b1; mul = 1'b1; alu_op = OP_ADD; rs_val = 16'h0003; use_imm = 1'b1;
    imm = 16'hFFFF; rt_val = 16'hBEEF; dest_in = 4'h7; wr_in = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_accept_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; mul = 1'b0;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mul_busy: %0d cycles with in_ready/out_valid high, required 0", bad);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, out_result, out_store, out_dest, out_wr} !== {1'b1, 16'hFFFD, 16'hBEEF, 4'h7, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_result: got %b %h %h %h %b required 1 fffd beef 7 1",
               out_valid, out_result, out_store, out_dest, out_wr);
    end
    n_checks++;
    if ({flag_n, flag_v, flag_z} !== {m_n, m_v, m_z}) begin
      n_fail++; $display("FAIL mul_flags: got %b required %b", {flag_n, flag_v, flag_z}, {m_n, m_v, m_z});
    end
    $display("txn mul a=0003 b=ffff result=%h", out_result);
    m_valid = 1'b1; m_result = 16'hFFFD; m_store = 16'hBEEF; m_dest = 4'h7; m_wr = 1'b1;
    apply_edge();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_drain: got %b required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    set_idle();
    out_ready = 1'b0; in_valid = 1'b1; alu_op = OP_ADD; rs_val = 16'h1000; use_imm = 1'b1;
    imm = 16'h0234; dest_in = 4'h1; wr_in = 1'b1;
    apply_edge();
    rs_val = 16'h8000; imm = 16'hFFFF; dest_in = 4'h2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
      apply_edge();
      n_checks++;
      if ({out_valid, out_result, out_store, out_dest, out_wr} !== {1'b1, 16'h1234, m_store, 4'h1, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold: got %b %h %h %h %b required 1 1234 %h 1 1",
                 out_valid, out_result, out_store, out_dest, out_wr, m_store);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
    apply_edge();
    n_checks++;
    if ({out_valid, out_result, out_dest, flag_n, flag_v, flag_z} !== {1'b1, 16'h8000, 4'h2, 3'b110}) begin
      n_fail++;
      $display("FAIL bp_queued_add: got v=%b res=%h dest=%h nvz=%b required v=1 res=8000 dest=2 nvz=110",
               out_valid, out_result, out_dest, {flag_n, flag_v, flag_z});
    end
    in_valid = 1'b0;
    apply_edge();
  endtask

  task automatic start_mul();
    set_idle();
    in_valid = 1'b1; mul = 1'b1; rs_val = 16'h0005; use_imm = 1'b1; imm = 16'h0007;
    @(posedge clk); #1;
    in_valid = 1'b0; mul = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    int seen;
    start_mul();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_flush: got ready=%b valid=%b required 1 0", in_ready, out_valid);
    end
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen++; end
    n_checks++;
    if (seen != 0 || {flag_n, flag_v, flag_z} !== {m_n, m_v, m_z}) begin
      n_fail++;
      $display("FAIL abort_flush_quiet: got %0d valid cycles nvz=%b required 0 %b",
               seen, {flag_n, flag_v, flag_z}, {m_n, m_v, m_z});
    end
    start_mul();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_rst: got ready=%b valid=%b required 1 0", in_ready, out_valid);
    end
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen++; end
    n_checks++;
    if (seen != 0 || {flag_n, flag_v, flag_z} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_rst_quiet: got %0d valid cycles nvz=%b required 0 000", seen, {flag_n, flag_v, flag_z});
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic exp_ready;
    set_idle();
    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      alu_op = 4'($urandom_range(0, 15));
      use_imm = 1'($urandom_range(0, 1));
      lhb = 1'($urandom_range(0, 1));
      llb = 1'($urandom_range(0, 1));
      fwd_a = 2'($urandom_range(0, 3));
      fwd_b = 2'($urandom_range(0, 3));
      rs_val = rnd16(); rt_val = rnd16(); imm = rnd16(); pc_plus2 = rnd16();
      fwd_exmem = rnd16(); fwd_memwb = rnd16();
      dest_in = 4'($urandom_range(0, 15)); wr_in = 1'($urandom_range(0, 1));
      #1;
      exp_ready = (!m_valid || out_ready) && !flush;
      n_checks++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_in_ready[%0d]: got %b required %b", n, in_ready, exp_ready);
      end
      apply_edge();
      n_checks++;
      if (out_valid !== m_valid ||
          (m_valid && {out_result, out_store, out_dest, out_wr} !== {m_result, m_store, m_dest, m_wr})) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got %b %h %h %h %b required %b %h %h %h %b", n,
                 out_valid, out_result, out_store, out_dest, out_wr,
                 m_valid, m_result, m_store, m_dest, m_wr);
      end
      n_checks++;
      if ({flag_n, flag_v, flag_z} !== {m_n, m_v, m_z}) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: got nvz=%b required %b", n, {flag_n, flag_v, flag_z}, {m_n, m_v, m_z});
      end
    end
    set_idle();
    apply_edge();
  endtask

  initial begin
    test_reset();
    test_add_sat();
    test_fwd_cat();
    test_lhb_merge();
    test_mul();
    test_backpressure();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
